collision_scanner: RTL and testbench

Time-multiplexed, parametrised collision detector between the player car and up to N_CARS enemy cars. On each frame tick it snapshots all positions, then checks one enemy per clock against the player bounding box. It publishes a per-car hit mask, the lowest colliding index and an aggregate collision flag with a one-cycle done strobe. It sits between the enemy/player position registers and the game-state controller, and supersedes the fixed six-car combinational checker.

---
 rtl/collision_scanner.sv | 199 +++++++++++++++++++
 tb/tb_collision_scanner.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/collision_scanner.sv
`default_nettype none
// ============================================================================
// Module   : collision_scanner
// Purpose  : Time-multiplexed bounding-box collision detector between the
//            player car and up to N_CARS enemy cars. A frame tick snapshots
//            all positions. One enemy is then checked per clock, and the
//            per-car hit mask, the lowest hit index and an aggregate
//            collision flag are published with a one-cycle done strobe.
// Ports    : clk, rst_n (async, active low)
//            i_frame_tick        start-of-scan pulse
//            i_car_x/i_car_y     packed enemy positions, car i at [i*W +: W]
//            i_car_en            per-car active mask
//            i_player_x/y        player position
//            i_clear             clears the sticky collision flag
//            o_busy, o_done      scan status / result strobe
//            o_hit_mask, o_hit_idx, o_colision, o_overrun  results
// Config   : `define COLLISION_STICKY_EN makes o_colision sticky until
//            i_clear. Without it, o_colision = |o_hit_mask and i_clear is
//            ignored.
// Revision : 1.0  initial release
// ============================================================================
module collision_scanner #(
    parameter int N_CARS = 6,
    parameter int X_W    = 8,
    parameter int Y_W    = 10,
    parameter int BOX_W  = 16,
    parameter int BOX_H  = 32,
    parameter int IDX_W  = (N_CARS > 1) ? $clog2(N_CARS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_frame_tick,
    input  logic [N_CARS*X_W-1:0] i_car_x,
    input  logic [N_CARS*Y_W-1:0] i_car_y,
    input  logic [N_CARS-1:0]     i_car_en,
    input  logic [X_W-1:0]        i_player_x,
    input  logic [Y_W-1:0]        i_player_y,
    input  logic                  i_clear,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [N_CARS-1:0]     o_hit_mask,
    output logic [IDX_W-1:0]      o_hit_idx,
    output logic                  o_colision,
    output logic                  o_overrun
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] c_last  = IDX_W'(N_CARS - 1);
    localparam logic [X_W:0]     c_box_w = (X_W + 1)'(BOX_W);
    localparam logic [Y_W:0]     c_box_h = (Y_W + 1)'(BOX_H);

    state_t                  r_state;
    state_t                  w_next;
    logic [IDX_W-1:0]        r_idx;
    logic [N_CARS-1:0]       r_mask;
    logic [N_CARS*X_W-1:0]   r_cx;
    logic [N_CARS*Y_W-1:0]   r_cy;
    logic [N_CARS-1:0]       r_en;
    logic [X_W-1:0]          r_px;
    logic [Y_W-1:0]          r_py;
    logic                    r_done;

    logic [X_W-1:0]          w_cx;
    logic [Y_W-1:0]          w_cy;
    logic                    w_en;
    logic [X_W:0]            w_dx;
    logic [Y_W:0]            w_dy;
    logic                    w_hit;
    logic [IDX_W-1:0]        w_first;

    // ------------------------------------------------------------------
    // State register and next-state logic
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_frame_tick) w_next = S_SCAN;
            S_SCAN:  if (r_idx == c_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Select the car under test from the snapshot
    // ------------------------------------------------------------------
    always_comb begin
        w_cx = '0;
        w_cy = '0;
        w_en = 1'b0;
        for (int i = 0; i < N_CARS; i++) begin
            if (r_idx == i[IDX_W-1:0]) begin
                w_cx = r_cx[i*X_W +: X_W];
                w_cy = r_cy[i*Y_W +: Y_W];
                w_en = r_en[i];
            end
        end
    end

    // Distances carry one guard bit so a far-apart pair can never wrap
    // into a small difference.
    assign w_dx  = (w_cx >= r_px) ? ({1'b0, w_cx} - {1'b0, r_px})
                                  : ({1'b0, r_px} - {1'b0, w_cx});
    assign w_dy  = (w_cy >= r_py) ? ({1'b0, w_cy} - {1'b0, r_py})
                                  : ({1'b0, r_py} - {1'b0, w_cy});
    // Strict compare: boxes that only touch edges do not collide.
    assign w_hit = w_en && (w_dx < c_box_w) && (w_dy < c_box_h);

    // Lowest set bit of the finished working mask; 0 when empty.
    always_comb begin
        w_first = '0;
        for (int i = N_CARS - 1; i >= 0; i--) begin
            if (r_mask[i]) w_first = i[IDX_W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Datapath: snapshot, scan, result publication
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_mask     <= '0;
            r_cx       <= '0;
            r_cy       <= '0;
            r_en       <= '0;
            r_px       <= '0;
            r_py       <= '0;
            r_done     <= 1'b0;
            o_hit_mask <= '0;
            o_hit_idx  <= '0;
            o_overrun  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_frame_tick && (r_state != S_IDLE)) o_overrun <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (i_frame_tick) begin
                        r_cx   <= i_car_x;
                        r_cy   <= i_car_y;
                        r_en   <= i_car_en;
                        r_px   <= i_player_x;
                        r_py   <= i_player_y;
                        r_mask <= '0;
                        r_idx  <= '0;
                    end
                end
                S_SCAN: begin
                    for (int i = 0; i < N_CARS; i++) begin
                        if (r_idx == i[IDX_W-1:0]) r_mask[i] <= w_hit;
                    end
                    r_idx <= r_idx + 1'b1;
                end
                S_DONE: begin
                    o_hit_mask <= r_mask;
                    o_hit_idx  <= w_first;
                    r_done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Aggregate collision flag
    // ------------------------------------------------------------------
`ifdef COLLISION_STICKY_EN
    // A new hit in DONE takes priority over a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           o_colision <= 1'b0;
        else if ((r_state == S_DONE) && |r_mask) o_colision <= 1'b1;
        else if (i_clear)                     o_colision <= 1'b0;
    end
`else
    logic w_unused_clear;
    assign w_unused_clear = i_clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 o_colision <= 1'b0;
        else if (r_state == S_DONE) o_colision <= |r_mask;
    end
`endif

    // busy covers the done cycle too, so it drops as the strobe ends.
    assign o_busy = (r_state != S_IDLE) || r_done;
    assign o_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_collision_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_collision_scanner
// Purpose  : Self-checking bench for collision_scanner with directed and
//            randomized scans against a behavioural overlap model.
// Revision : 1.0  initial release
// ============================================================================
module tb_collision_scanner;

    localparam int N   = 6;
    localparam int XW  = 8;
    localparam int YW  = 10;
    localparam int IW  = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            frame_tick = 1'b0;
    logic [N*XW-1:0] car_x = '0;
    logic [N*YW-1:0] car_y = '0;
    logic [N-1:0]    car_en = '0;
    logic [XW-1:0]   player_x = '0;
    logic [YW-1:0]   player_y = '0;
    logic            clear = 1'b0;
    logic            busy, done, colision, overrun;
    logic [N-1:0]    hit_mask;
    logic [IW-1:0]   hit_idx;

    logic [XW-1:0]   cx [N];
    logic [YW-1:0]   cy [N];
    logic            exp_col = 1'b0;
    int              n_vec = 0;
    int              n_err = 0;

    collision_scanner #(.N_CARS(N), .X_W(XW), .Y_W(YW)) dut (
        .clk(clk), .rst_n(rst_n), .i_frame_tick(frame_tick),
        .i_car_x(car_x), .i_car_y(car_y), .i_car_en(car_en),
        .i_player_x(player_x), .i_player_y(player_y), .i_clear(clear),
        .o_busy(busy), .o_done(done), .o_hit_mask(hit_mask),
        .o_hit_idx(hit_idx), .o_colision(colision), .o_overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Overlap rule from plain integer distances.
    function automatic logic [N-1:0] model_mask();
        logic [N-1:0] m = '0;
        for (int i = 0; i < N; i++) begin
            int dx = int'(cx[i]) - int'(player_x);
            int dy = int'(cy[i]) - int'(player_y);
            if (dx < 0) dx = -dx;
            if (dy < 0) dy = -dy;
            m[i] = car_en[i] && (dx < 16) && (dy < 32);
        end
        return m;
    endfunction

    function automatic logic [IW-1:0] lowest(input logic [N-1:0] m);
        for (int i = 0; i < N; i++) if (m[i]) return IW'(i);
        return '0;
    endfunction

    task automatic park_all();
        for (int i = 0; i < N; i++) begin cx[i] = 8'd200; cy[i] = 10'd600; end
    endtask

    // Runs one scan from the cx/cy arrays and checks latency and results.
    task automatic run_scan(input string tag);
        logic [N-1:0] em;
        int lat;
        for (int i = 0; i < N; i++) begin
            car_x[i*XW +: XW] = cx[i];
            car_y[i*YW +: YW] = cy[i];
        end
        em = model_mask();
`ifdef COLLISION_STICKY_EN
        if (|em) exp_col = 1'b1;
`else
        exp_col = |em;
`endif
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        // Scribble inputs: the running scan must use the snapshot.
        car_x = {N*XW{1'b0}} | {$urandom, $urandom};
        car_y = {N*YW{1'b0}} | {$urandom, $urandom};
        car_en = ~car_en;
        player_x = XW'($urandom);
        player_y = YW'($urandom);
        lat = 0;
        while (!done && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, lat, N + 1);
        check({tag, " mask"}, hit_mask, em);
        check({tag, " idx"}, hit_idx, lowest(em));
        check({tag, " colision"}, colision, exp_col);
        check({tag, " busy_in_done"}, busy, 1'b1);
        @(negedge clk);
        check({tag, " done_1cyc"}, done, 1'b0);
        check({tag, " busy_fall"}, busy, 1'b0);
        check({tag, " mask_hold"}, hit_mask, em);
    endtask

    task automatic set_player(input int x, input int y, input logic [N-1:0] en);
        player_x = XW'(x);
        player_y = YW'(y);
        car_en   = en;
    endtask

    initial begin
        int dones;
        park_all();
        #12;
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst mask", hit_mask, 0);
        check("rst col", colision, 0);
        check("rst ovr", overrun, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single hit on car 3
        park_all(); cx[3] = 8'd110; cy[3] = 10'd220;
        set_player(100, 200, 6'h3F);
        run_scan("car3");

        // Exact edges do not collide
        park_all(); cx[0] = 8'd116; cy[0] = 10'd200; cx[1] = 8'd100; cy[1] = 10'd232;
        set_player(100, 200, 6'h3F);
        run_scan("edges");
        park_all(); cx[0] = 8'd115; cy[0] = 10'd200; cx[1] = 8'd100; cy[1] = 10'd232;
        set_player(100, 200, 6'h3F);
        run_scan("edge_in");

        // Disabled car 5 ignored
        park_all(); cx[2] = 8'd95; cy[2] = 10'd190; cx[5] = 8'd100; cy[5] = 10'd200;
        set_player(100, 200, 6'b011111);
        run_scan("en_mask");

        // Wrap-around
        park_all(); cx[0] = 8'd5; cy[0] = 10'd10;
        set_player(250, 1000, 6'h3F);
        run_scan("wrap_far");
        park_all(); cx[0] = 8'd0; cy[0] = 10'd0;
        set_player(3, 3, 6'h3F);
        run_scan("wrap_near");

        // Hit scan then clean scan (sticky-mode dependent), then clear
        park_all(); cx[4] = 8'd101; cy[4] = 10'd201;
        set_player(101, 201, 6'h3F);
        run_scan("pre_clean");
        park_all();
        set_player(101, 201, 6'h3F);
        run_scan("clean");
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
`ifdef COLLISION_STICKY_EN
        exp_col = 1'b0;
`endif
        check("after_clear col", colision, exp_col);

        // Randomized scans, half of the cars near the player
        for (int t = 0; t < 40; t++) begin
            int px = $urandom_range(0, 255);
            int py = $urandom_range(0, 1023);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    cx[i] = XW'(px + $urandom_range(0, 40) - 20);
                    cy[i] = YW'(py + $urandom_range(0, 70) - 35);
                end else begin
                    cx[i] = XW'($urandom);
                    cy[i] = YW'($urandom);
                end
            end
            set_player(px, py, N'($urandom));
            run_scan("rand");
        end
        check("no_overrun", overrun, 0);

        // Overrun: second tick 3 cycles into the scan
        park_all(); cx[1] = 8'd50; cy[1] = 10'd50;
        for (int i = 0; i < N; i++) begin
            car_x[i*XW +: XW] = cx[i];
            car_y[i*YW +: YW] = cy[i];
        end
        set_player(50, 50, 6'h3F);
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        @(negedge clk); @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("ovr flag", overrun, 1);
        check("ovr dones", dones, 1);
        check("ovr mask", hit_mask, 6'b000010);

        // Asynchronous reset mid-scan
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        @(negedge clk); @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst busy", busy, 0);
        check("arst done", done, 0);
        check("arst mask", hit_mask, 0);
        check("arst idx", hit_idx, 0);
        check("arst col", colision, 0);
        check("arst ovr", overrun, 0);
        @(negedge clk); rst_n = 1'b1;
        exp_col = 1'b0;

        // Recovery scan after reset
        park_all(); cx[5] = 8'd30; cy[5] = 10'd700;
        set_player(40, 710, 6'h3F);
        run_scan("recover");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
